// File: rtl/mips_pkg.sv
// Shared MIPS encodings, ALU operation set and decoded control word.
// Imported by the processor top and its ALU evaluation.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst_rd;
    logic    alu_src_imm;
    logic    mem_to_reg;
    logic    mem_write;
    logic    branch;
    alu_op_t alu_op;
  } ctrl_t;

  function automatic logic [31:0] alu_eval(input alu_op_t op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    res = a + b;
    case (op)
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_mem.sv
// Word-addressed memory array with combinational read and one clocked write port.
// Read is zero-latency; a write lands on the rising edge, same-cycle reads see old data.
module mips_mem #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] memory [0:DEPTH-1];

  assign rdata = memory[addr];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port.
// Register 0 reads as zero and ignores writes; contents are never reset.
module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regFile [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regFile[ra2];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) regFile[wa] <= wd;
  end

endmodule

// File: rtl/single_cycle_mips_processor.sv
// Single-cycle MIPS subset (add/sub/and/or/slt/addi/lw/sw/beq), one instruction per clk edge.
// Optional j instruction enabled by defining MIPS_JUMP_EN; otherwise opcode 000010 is a no-op.
module single_cycle_mips_processor
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] alu_result;
  logic [31:0] read_data;
  logic [31:0] imm_sext;
  logic [31:0] alu_b;
  logic [31:0] wb_data;
  logic [31:0] branch_target;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wb_addr;
  logic        rf_we;
  logic        dm_we;
  ctrl_t       ctrl;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  mips_mem #(.DEPTH(IMEM_DEPTH)) im (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[IAW+1:2]),
    .wdata (32'd0),
    .rdata (instr)
  );

  always_comb begin
    ctrl = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst_rd = 1'b1;
        ctrl.reg_write  = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_BEQ:  ctrl.branch = 1'b1;
      // Jump only redirects the pc; it never writes state.
      OP_J:    ctrl.branch = 1'b0;
      default: ctrl.branch = 1'b0;
    endcase
  end

  // Writes are suppressed while reset is high so the in-flight instruction is discarded.
  assign rf_we = ctrl.reg_write & ~reset;
  assign dm_we = ctrl.mem_write & ~reset;

  mips_regfile rf (
    .clk (clk),
    .we  (rf_we),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wb_addr),
    .wd  (wb_data),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  assign alu_b      = ctrl.alu_src_imm ? imm_sext : rd2;
  assign alu_result = alu_eval(ctrl.alu_op, rd1, alu_b);

  // Byte-sum is used directly as the word index; upper address bits wrap.
  mips_mem #(.DEPTH(DMEM_DEPTH)) dm (
    .clk   (clk),
    .we    (dm_we),
    .addr  (alu_result[DAW-1:0]),
    .wdata (rd2),
    .rdata (read_data)
  );

  assign wb_addr = ctrl.reg_dst_rd ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? read_data : alu_result;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.branch && (rd1 == rd2)) pc_next = branch_target;
`ifdef MIPS_JUMP_EN
    if (opcode == OP_J) pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= 32'd0;
    else       pc <= pc_next;
  end

endmodule

// File: tb/tb_single_cycle_mips_processor.sv
// Directed program test for the single-cycle MIPS core, using backdoor preload and hierarchical observation.
module tb_single_cycle_mips_processor;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  single_cycle_mips_processor dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) dut.im.memory[i] = 32'd0;
    for (int i = 0; i < 256; i++) dut.dm.memory[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.rf.regFile[i] = 32'd0;
    dut.rf.regFile[8]  = 32'd12;
    dut.rf.regFile[9]  = 32'd20;
    dut.rf.regFile[10] = 32'd30;
    dut.rf.regFile[11] = 32'd42;
    dut.dm.memory[12]  = 32'd100;
    dut.im.memory[0]  = enc_r(5'd8, 5'd10, 5'd9, 6'b100000);       // add $t1,$t0,$t2
    dut.im.memory[1]  = enc_r(5'd9, 5'd8, 5'd12, 6'b100010);       // sub $t4,$t1,$t0
    dut.im.memory[2]  = enc_i(6'b100011, 5'd8, 5'd10, 16'd0);      // lw $t2,0($t0)
    dut.im.memory[3]  = enc_i(6'b101011, 5'd8, 5'd11, 16'd4);      // sw $t3,4($t0)
    dut.im.memory[4]  = enc_i(6'b000100, 5'd11, 5'd9, 16'd1);      // beq $t3,$t1,+1
    dut.im.memory[5]  = enc_r(5'd8, 5'd8, 5'd13, 6'b100000);       // add $t5 (skipped)
    dut.im.memory[6]  = enc_i(6'b101011, 5'd8, 5'd12, 16'd8);      // sw $t4,8($t0)
    dut.im.memory[7]  = enc_r(5'd8, 5'd10, 5'd0, 6'b100000);       // add $zero,$t0,$t2
    dut.im.memory[8]  = enc_i(6'b000100, 5'd8, 5'd9, 16'd5);       // beq $t0,$t1,+5 (not taken)
    dut.im.memory[9]  = enc_i(6'b001000, 5'd0, 5'd14, 16'hFFFF);   // addi $t6,$zero,-1
    dut.im.memory[10] = enc_i(6'b001000, 5'd0, 5'd15, 16'd1);      // addi $t7,$zero,1
    dut.im.memory[11] = enc_r(5'd14, 5'd15, 5'd16, 6'b101010);     // slt $s0,$t6,$t7
    dut.im.memory[12] = enc_r(5'd8, 5'd9, 5'd17, 6'b100100);       // and $s1,$t0,$t1
    dut.im.memory[13] = enc_r(5'd8, 5'd9, 5'd18, 6'b100101);       // or $s2,$t0,$t1
    dut.im.memory[14] = enc_i(6'b111111, 5'd8, 5'd19, 16'd3);      // unsupported opcode
    dut.im.memory[15] = {6'b000010, 26'd16};                       // j 16 (word 16 either way)
    dut.im.memory[16] = enc_i(6'b100011, 5'd8, 5'd20, 16'd256);    // lw $s4,256($t0) wraps to dm[12]
    dut.im.memory[17] = enc_i(6'b001000, 5'd0, 5'd19, 16'd7);      // addi $s3 (discarded by reset)
  endtask

  task automatic test_reset();
    checks++;
    if (dut.pc !== 32'd0) begin
      errors++; $display("FAIL reset_pc got %0d want 0", dut.pc);
    end
    checks++;
    if (dut.rf.regFile[8] !== 32'd12) begin
      errors++; $display("FAIL reset_preload_t0 got %0d want 12", dut.rf.regFile[8]);
    end
  endtask

  task automatic test_rtype_arith();
    step();
    checks++;
    if (dut.rf.regFile[9] !== 32'd42) begin
      errors++; $display("FAIL add_t1 got %0d want 42", dut.rf.regFile[9]);
    end
    checks++;
    if (dut.pc !== 32'd4) begin
      errors++; $display("FAIL add_pc got %0d want 4", dut.pc);
    end
    step();
    checks++;
    if (dut.rf.regFile[12] !== 32'd30) begin
      errors++; $display("FAIL sub_t4 got %0d want 30", dut.rf.regFile[12]);
    end
  endtask

  task automatic test_load_store();
    checks++;
    if (dut.read_data !== 32'd100) begin
      errors++; $display("FAIL lw_read_data got %0d want 100", dut.read_data);
    end
    step();
    checks++;
    if (dut.rf.regFile[10] !== 32'd100) begin
      errors++; $display("FAIL lw_t2 got %0d want 100", dut.rf.regFile[10]);
    end
    step();
    checks++;
    if (dut.dm.memory[16] !== 32'd42) begin
      errors++; $display("FAIL sw_dm16 got %0d want 42", dut.dm.memory[16]);
    end
    checks++;
    if (dut.rf.regFile[11] !== 32'd42 || dut.rf.regFile[10] !== 32'd100) begin
      errors++; $display("FAIL sw_no_reg_write got t3=%0d t2=%0d want 42 100",
                         dut.rf.regFile[11], dut.rf.regFile[10]);
    end
  endtask

  task automatic test_branch_taken();
    step();
    checks++;
    if (dut.pc !== 32'd24) begin
      errors++; $display("FAIL beq_taken_pc got %0d want 24", dut.pc);
    end
    step();
    checks++;
    if (dut.rf.regFile[13] !== 32'd0) begin
      errors++; $display("FAIL beq_skip_t5 got %0d want 0", dut.rf.regFile[13]);
    end
    checks++;
    if (dut.dm.memory[20] !== 32'd30) begin
      errors++; $display("FAIL sw_dm20 got %0d want 30", dut.dm.memory[20]);
    end
  endtask

  task automatic test_zero_reg();
    step();
    checks++;
    if (dut.rf.regFile[0] !== 32'd0 || dut.rd1 !== 32'd12) begin
      errors++; $display("FAIL zero_reg got r0=%0d rd1=%0d want 0 12", dut.rf.regFile[0], dut.rd1);
    end
  endtask

  task automatic test_branch_not_taken();
    step();
    checks++;
    if (dut.pc !== 32'd36) begin
      errors++; $display("FAIL beq_not_taken_pc got %0d want 36", dut.pc);
    end
  endtask

  task automatic test_addi_slt_logic();
    step();
    checks++;
    if (dut.rf.regFile[14] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL addi_neg got %h want ffffffff", dut.rf.regFile[14]);
    end
    step();
    step();
    checks++;
    if (dut.rf.regFile[16] !== 32'd1) begin
      errors++; $display("FAIL slt_signed got %0d want 1", dut.rf.regFile[16]);
    end
    step();
    checks++;
    if (dut.rf.regFile[17] !== 32'd8) begin
      errors++; $display("FAIL and_s1 got %0d want 8", dut.rf.regFile[17]);
    end
    step();
    checks++;
    if (dut.rf.regFile[18] !== 32'd46) begin
      errors++; $display("FAIL or_s2 got %0d want 46", dut.rf.regFile[18]);
    end
  endtask

  task automatic test_unsupported();
    step();
    checks++;
    if (dut.pc !== 32'd60 || dut.rf.regFile[19] !== 32'd0) begin
      errors++; $display("FAIL unsupported_op got pc=%0d s3=%0d want 60 0", dut.pc, dut.rf.regFile[19]);
    end
    step();
    checks++;
    if (dut.pc !== 32'd64) begin
      errors++; $display("FAIL j_opcode_pc got %0d want 64", dut.pc);
    end
  endtask

  task automatic test_lw_wrap();
    step();
    checks++;
    if (dut.rf.regFile[20] !== 32'd100) begin
      errors++; $display("FAIL lw_wrap_s4 got %0d want 100", dut.rf.regFile[20]);
    end
  endtask

  task automatic test_reset_mid_run();
    reset = 1'b1;
    step();
    checks++;
    if (dut.pc !== 32'd0) begin
      errors++; $display("FAIL midreset_pc got %0d want 0", dut.pc);
    end
    checks++;
    if (dut.rf.regFile[19] !== 32'd0 || dut.rf.regFile[20] !== 32'd100) begin
      errors++; $display("FAIL midreset_regs got s3=%0d s4=%0d want 0 100",
                         dut.rf.regFile[19], dut.rf.regFile[20]);
    end
    reset = 1'b0;
    step();
    checks++;
    if (dut.rf.regFile[9] !== 32'd112 || dut.pc !== 32'd4) begin
      errors++; $display("FAIL restart_add got t1=%0d pc=%0d want 112 4", dut.rf.regFile[9], dut.pc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    load_program();
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_rtype_arith();
    test_load_store();
    test_branch_taken();
    test_zero_reg();
    test_branch_not_taken();
    test_addi_slt_logic();
    test_unsupported();
    test_lw_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_cycle_mips_processor.md
SINGLE_CYCLE_MIPS_PROCESSOR -- requirements
Module: single_cycle_mips_processor

Interface
REQ-001 Parameter IMEM_DEPTH, default 64: instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_DEPTH, default 256: data memory depth in 32-bit words.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 No other ports; observation is hierarchical only.
REQ-006 Internal 32-bit nets named pc, instr, rd1, rd2, alu_result, read_data.
REQ-007 Instances: im (array memory[0:IMEM_DEPTH-1]), rf (array regFile[0:31]) and dm (array memory[0:DMEM_DEPTH-1]), all 32-bit words and backdoor-writable.

Function
REQ-008 Single cycle: one instruction completes per clk edge; CPI = 1.
REQ-009 instr = im.memory[pc[log2(IMEM_DEPTH)+1:2]], combinational.
REQ-010 rd1 = regFile[rs] and rd2 = regFile[rt], combinational; register 0 always reads 0 and writes to it are ignored.
REQ-011 R-type (opcode 000000) writes rd, selected by funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed, result 1/0).
REQ-012 Arithmetic is 32-bit wrap-around; no overflow exceptions.
REQ-013 addi (001000): rt = rs + sign-extended imm16.
REQ-014 lw (100011): rt = read_data, where read_data = dm.memory[alu_result[log2(DMEM_DEPTH)-1:0]] and alu_result = rs + sext(imm).
REQ-015 The data address is the byte-sum used directly as the word index, with no >>2 (e.g. address 16 selects memory[16]).
REQ-016 Address bits above the index width are ignored (wrap).
REQ-017 sw (101011): writes rd2 into dm.memory at the same index on the clock edge; no register write.
REQ-018 beq (000100): if rd1 == rd2, next pc = pc+4 + (sext(imm)<<2); otherwise next pc = pc+4.
REQ-019 Default next pc = pc+4; pc wraps modulo 2^32.
REQ-020 Unsupported opcode or funct: no register or memory write; pc+4.
REQ-021 Register and memory writes take effect at the clock edge; a read in the same cycle returns the old value.
REQ-022 read_data is always driven, even for non-load instructions.

Reset
REQ-023 While reset is high at a clock edge: pc <= 0, and no register or memory write occurs.
REQ-024 Register file and memories are not cleared by reset, so contents preloaded during or after reset persist.
REQ-025 Reset asserted mid-program: the next edge forces pc = 0 and the in-flight instruction is discarded.

Configuration
REQ-026 Macro MIPS_JUMP_EN defined: j (000010) sets next pc = {pc_plus4[31:28], target26, 2'b00}.
REQ-027 Macro MIPS_JUMP_EN undefined: opcode 000010 is handled as an unsupported opcode (pc+4, no writes).

Structure
REQ-028 Shared package mips_pkg holds the opcode constants, the funct constants and the ALU-operation enum typedef.
REQ-029 The natural sub-module is mips_regfile (instance rf: 2 read ports, 1 write port).
REQ-030 Instruction memory, data memory, control decoder and ALU may be separate blocks but keep the instance names im and dm.

Verification
REQ-031 Preload $t0=12, $t1=20, $t2=30, $t3=42, dm[12]=100; run add $t1,$t0,$t2 -> $t1=42 after the first post-reset edge.
REQ-032 Next, sub $t4,$t1,$t0 -> $t4=30.
REQ-033 Next, lw $t2,0($t0) -> $t2=100, and read_data=100 during that cycle.
REQ-034 Next, sw $t3,4($t0) -> dm[16]=42, with no register change.
REQ-035 Next, beq $t3,$t1,+1 with both equal to 42 -> the following add $t5 is skipped ($t5 stays 0), and sw $t4,8($t0) gives dm[20]=30.
REQ-036 Corner cases: add targeting $zero -> reads 0; reset pulsed mid-run -> pc=0 next edge with registers retained; beq with unequal operands -> pc+4; slt -1,1 -> 1.
